// File: rtl/shift_reg_univ.sv
// shift_reg_univ: WIDTH-bit universal register (clear, preset, enable, load,
// shift, rotate, invert) with true/complement outputs and serial taps.
// Optional frame counter (CNT/DONE) is built only when SHIFT_CNT_EN is defined;
// otherwise CNT and DONE are tied low.
module shift_reg_univ #(
  parameter int              WIDTH      = 8,
  parameter logic [WIDTH-1:0] PRESET_VAL = '1
) (
  input  logic                     CLK,
  input  logic                     CLR,
  input  logic                     PR,
  input  logic                     EN,
  input  logic [2:0]               MODE,
  input  logic                     SIN_L,
  input  logic                     SIN_R,
  input  logic [WIDTH-1:0]         D,
  output logic [WIDTH-1:0]         Q,
  output logic [WIDTH-1:0]         Qn,
  output logic                     SOUT_L,
  output logic                     SOUT_R,
  output logic                     DONE,
  output logic [$clog2(WIDTH)-1:0] CNT
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_INV  = 3'b110;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;

  // Next register value for the selected mode; reserved code 111 holds.
  always_comb begin
    q_next = q;
    case (MODE)
      M_HOLD:  q_next = q;
      M_SHL:   q_next = {q[WIDTH-2:0], SIN_R};
      M_SHR:   q_next = {SIN_L, q[WIDTH-1:1]};
      M_LOAD:  q_next = D;
      M_ROL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      M_ROR:   q_next = {q[0], q[WIDTH-1:1]};
      M_INV:   q_next = ~q;
      default: q_next = q;
    endcase
  end

  // Data register: async clear, then preset, then enabled mode operation.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      q <= '0;
    end else if (PR) begin
      q <= PRESET_VAL;
    end else if (EN) begin
      q <= q_next;
    end
  end

  assign Q      = q;
  assign Qn     = ~q;
  assign SOUT_L = q[WIDTH-1];
  assign SOUT_R = q[0];

`ifdef SHIFT_CNT_EN
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;
  logic          done;
  logic          is_shift;

  // Shift and rotate edges are the ones that advance the frame count.
  always_comb begin
    is_shift = EN && ((MODE == M_SHL) || (MODE == M_SHR) ||
                      (MODE == M_ROL) || (MODE == M_ROR));
  end

  // Frame counter; DONE is a one-cycle registered pulse on frame wrap.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (PR) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (EN && (MODE == M_LOAD)) begin
        cnt <= '0;
      end else if (is_shift) begin
        if (cnt == CNT_LAST) begin
          cnt  <= '0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign CNT  = cnt;
  assign DONE = done;
`else
  assign CNT  = '0;
  assign DONE = 1'b0;
`endif

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ (WIDTH=8, PRESET_VAL=8'hFF).
// Works in both builds; counter expectations depend on SHIFT_CNT_EN.
module tb_shift_reg_univ;

  localparam int W = 8;
`ifdef SHIFT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         clr;
  logic         pr;
  logic         en;
  logic [2:0]   mode;
  logic         sin_l;
  logic         sin_r;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic [W-1:0] qn;
  logic         sout_l;
  logic         sout_r;
  logic         done;
  logic [2:0]   cnt;

  int checks   = 0;
  int failures = 0;

  // reference model state (plain integers)
  int m_q;
  int m_cnt;
  int m_done;

  shift_reg_univ #(.WIDTH(W), .PRESET_VAL(8'hFF)) dut (
    .CLK(clk), .CLR(clr), .PR(pr), .EN(en), .MODE(mode),
    .SIN_L(sin_l), .SIN_R(sin_r), .D(d),
    .Q(q), .Qn(qn), .SOUT_L(sout_l), .SOUT_R(sout_r),
    .DONE(done), .CNT(cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit   p;
    bit   e;
    int   md;
    bit   sl;
    bit   sr;
    int   dd;
    int   exp_q;
  } vec_t;

  vec_t tbl[16];
  int   n_vec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"},      32'(q),      32'(m_q));
    chk({tag, ".qn"},     32'(qn),     32'(255 - m_q));
    chk({tag, ".sout_l"}, 32'(sout_l), 32'(m_q / 128));
    chk({tag, ".sout_r"}, 32'(sout_r), 32'(m_q % 2));
    chk({tag, ".cnt"},    32'(cnt),    32'(m_cnt));
    chk({tag, ".done"},   32'(done),   32'(m_done));
  endtask

  task automatic model_reset();
    m_q = 0; m_cnt = 0; m_done = 0;
  endtask

  // Arithmetic view of each mode; frame count counts to W shifts.
  task automatic model_edge(input bit p, input bit e, input int md,
                            input bit sl, input bit sr, input int dd);
    bit shifted;
    shifted = 1'b0;
    m_done  = 0;
    if (p) begin
      m_q = 255; m_cnt = 0;
    end else if (e) begin
      case (md)
        1: begin m_q = (m_q * 2 + int'(sr)) % 256;        shifted = 1'b1; end
        2: begin m_q = m_q / 2 + int'(sl) * 128;          shifted = 1'b1; end
        3: begin m_q = dd % 256; m_cnt = 0; end
        4: begin m_q = (m_q * 2) % 256 + m_q / 128;       shifted = 1'b1; end
        5: begin m_q = m_q / 2 + (m_q % 2) * 128;         shifted = 1'b1; end
        6: m_q = 255 - m_q;
        default: ;
      endcase
      if (shifted && CNT_ON) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == W) begin
          m_cnt = 0; m_done = 1;
        end
      end
    end
  endtask

  task automatic apply(input bit p, input bit e, input int md,
                       input bit sl, input bit sr, input int dd);
    pr = p; en = e; mode = 3'(md); sin_l = sl; sin_r = sr; d = 8'(dd);
    @(posedge clk);
    model_edge(p, e, md, sl, sr, dd);
    #1;
  endtask

  // Raise CLR between edges, check immediate clear, hold it across edges.
  task automatic async_clear(input int hold_edges);
    #3;
    clr = 1'b1;
    #1;
    model_reset();
    check_all("clr_async");
    for (int i = 0; i < hold_edges; i++) begin
      pr = 1'b0; en = 1'b1; mode = 3'd3; d = 8'h77;
      @(posedge clk);
      #1;
      check_all("clr_hold");
    end
    #2;
    clr = 1'b0;
  endtask

  initial begin
    clr = 1'b1; pr = 1'b0; en = 1'b0; mode = 3'd0;
    sin_l = 1'b0; sin_r = 1'b0; d = '0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    check_all("reset_edge");
    #2;
    clr = 1'b0;

    // directed table
    tbl[0]  = '{0, 1, 3, 0, 0, 'hA5, 'hA5};
    tbl[1]  = '{0, 1, 1, 0, 1, 'h00, 'h4B};
    tbl[2]  = '{0, 1, 2, 0, 0, 'h00, 'h25};
    tbl[3]  = '{0, 1, 3, 0, 0, 'h81, 'h81};
    tbl[4]  = '{0, 1, 4, 0, 0, 'h00, 'h03};
    tbl[5]  = '{0, 1, 5, 0, 0, 'h00, 'h81};
    tbl[6]  = '{0, 1, 5, 0, 0, 'h00, 'hC0};
    tbl[7]  = '{0, 1, 6, 0, 0, 'h00, 'h3F};
    tbl[8]  = '{0, 0, 3, 0, 0, 'h12, 'h3F};
    tbl[9]  = '{1, 1, 3, 0, 0, 'h12, 'hFF};
    tbl[10] = '{0, 1, 3, 0, 0, 'h00, 'h00};
    tbl[11] = '{1, 0, 0, 0, 0, 'h00, 'hFF};
    tbl[12] = '{0, 1, 7, 1, 1, 'h00, 'hFF};
    tbl[13] = '{0, 1, 0, 1, 1, 'h00, 'hFF};
    tbl[14] = '{0, 1, 3, 0, 0, 'h5A, 'h5A};
    tbl[15] = '{0, 1, 6, 0, 0, 'h00, 'hA5};
    n_vec = 16;
    for (int i = 0; i < n_vec; i++) begin
      apply(tbl[i].p, tbl[i].e, tbl[i].md, tbl[i].sl, tbl[i].sr, tbl[i].dd);
      chk($sformatf("vec%0d.q", i), 32'(q), 32'(tbl[i].exp_q));
      check_all($sformatf("vec%0d", i));
    end

    // async clear after a load
    apply(0, 1, 3, 0, 0, 'hA5);
    chk("pre_clr.q", 32'(q), 32'hA5);
    async_clear(3);

    // one full frame of rotate-left from 8'h01
    apply(0, 1, 3, 0, 0, 'h01);
    for (int i = 0; i < 8; i++) begin
      apply(0, 1, 4, 0, 0, 0);
      chk($sformatf("frame%0d.q", i),    32'(q),    32'(1 << ((i + 1) % 8)));
      chk($sformatf("frame%0d.done", i), 32'(done), 32'(CNT_ON && i == 7));
      chk($sformatf("frame%0d.cnt", i),  32'(cnt),  32'(CNT_ON ? (i + 1) % 8 : 0));
    end
    apply(0, 1, 0, 0, 0, 0);
    chk("frame_after.done", 32'(done), 32'd0);

    // interrupted frame: 5 shifts, gap, load, then 8 shifts
    apply(0, 1, 3, 0, 0, 'h3C);
    for (int i = 0; i < 5; i++) apply(0, 1, 1, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      apply(0, 0, 1, 0, 0, 0);
      chk("gap.cnt",  32'(cnt),  32'(CNT_ON ? 5 : 0));
      chk("gap.done", 32'(done), 32'd0);
      check_all("gap");
    end
    apply(0, 1, 3, 0, 0, 'hC3);
    chk("reload.cnt", 32'(cnt), 32'd0);
    for (int i = 0; i < 8; i++) begin
      apply(0, 1, 2, 1, 0, 0);
      chk($sformatf("intr%0d.done", i), 32'(done), 32'(CNT_ON && i == 7));
      check_all("intr");
    end

    // clear in the middle of a frame restarts the count
    for (int i = 0; i < 3; i++) apply(0, 1, 5, 0, 0, 0);
    async_clear(1);
    apply(0, 1, 4, 0, 0, 0);
    chk("post_clr.cnt", 32'(cnt), 32'(CNT_ON ? 1 : 0));

    // randomized run against the model
    for (int i = 0; i < 800; i++) begin
      bit p, e, sl, sr;
      int md, dd;
      if ($urandom_range(0, 59) == 0) begin
        async_clear($urandom_range(0, 2));
        continue;
      end
      p  = ($urandom_range(0, 19) == 0);
      e  = ($urandom_range(0, 4) != 0);
      md = $urandom_range(0, 7);
      if ($urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 3))
          0: md = 1;
          1: md = 2;
          2: md = 4;
          default: md = 5;
        endcase
      end
      sl = 1'($urandom_range(0, 1));
      sr = 1'($urandom_range(0, 1));
      dd = $urandom_range(0, 255);
      apply(p, e, md, sl, sr, dd);
      check_all("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
